// File: rtl/arm_alu_mc.sv
// Multi-cycle ARM ALU/shifter with iterative multiplier.
// Result and NZCV are registered behind a start/busy/done handshake.
module arm_alu_mc #(
  parameter int WIDTH = 32,
  parameter int MUL_K = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [3:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic                     carry_in,
  input  logic                     overflow_in,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic [3:0]               flags
);

  localparam int N  = WIDTH / MUL_K;
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0111;
  localparam logic [3:0] OP_LSL = 4'b1000;
  localparam logic [3:0] OP_LSR = 4'b1001;
  localparam logic [3:0] OP_ASR = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  function automatic logic [3:0] nzcv(
    input logic [WIDTH-1:0] r,
    input logic             c,
    input logic             v
  );
    return {r[WIDTH-1], ~|r, c, v};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cin_q, cin_d;
  logic             vin_q, vin_d;

  logic [WIDTH-1:0] add_x, add_y;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic             add_v;
  logic [WIDTH:0]   lsl_ext, lsr_ext, asr_ext;
  logic [SW:0]      rot_l;
  logic [WIDTH-1:0] ror_res;
  logic             sh_zero;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH-1:0] mul_sum;

  // Adder operand select; SUB/RSB/SBC use the inverted-operand form.
  always_comb begin
    add_x = a;
    add_y = b;
    add_c = 1'b0;
    unique case (op)
      OP_SUB: begin
        add_y = ~b;
        add_c = 1'b1;
      end
      OP_RSB: begin
        add_x = b;
        add_y = ~a;
        add_c = 1'b1;
      end
      OP_ADC: add_c = carry_in;
      OP_SBC: begin
        add_y = ~b;
        add_c = carry_in;
      end
      default: ;
    endcase
  end

  assign sum   = {1'b0, add_x} + {1'b0, add_y}
               + {{WIDTH{1'b0}}, add_c};
  assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1])
               && (sum[WIDTH-1] != add_x[WIDTH-1]);

  // Extended shifts keep the last bit shifted out in the extra position.
  assign lsl_ext = {1'b0, a} << shamt;
  assign lsr_ext = {a, 1'b0} >> shamt;
  assign asr_ext = $signed({a, 1'b0}) >>> shamt;
  assign rot_l   = (SW + 1)'(WIDTH) - {1'b0, shamt};
  assign ror_res = (a >> shamt) | (a << rot_l);
  assign sh_zero = (shamt == '0);

  always_comb begin
    alu_res = '0;
    alu_c   = carry_in;
    alu_v   = overflow_in;
    unique case (op)
      OP_AND: alu_res = a & b;
      OP_EOR: alu_res = a ^ b;
      OP_SUB, OP_RSB, OP_ADD,
      OP_ADC, OP_SBC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = add_v;
      end
      OP_MUL: alu_res = '0;
      OP_LSL: begin
        alu_res = lsl_ext[WIDTH-1:0];
        if (!sh_zero) alu_c = lsl_ext[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr_ext[WIDTH:1];
        if (!sh_zero) alu_c = lsr_ext[0];
      end
      OP_ASR: begin
        alu_res = asr_ext[WIDTH:1];
        if (!sh_zero) alu_c = asr_ext[0];
      end
      OP_ROR: begin
        alu_res = ror_res;
        if (!sh_zero) alu_c = ror_res[WIDTH-1];
      end
      OP_ORR: alu_res = a | b;
      OP_MOV: alu_res = b;
      OP_BIC: alu_res = a & ~b;
      OP_MVN: alu_res = ~b;
    endcase
  end

  // One multiplier slice: add shifted multiplicand for each of MUL_K bits.
  always_comb begin
    mul_sum = acc_q;
    for (int k = 0; k < MUL_K; k++) begin
      if (mul_b_q[k]) mul_sum = mul_sum + (mul_a_q << k);
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    cin_d    = cin_q;
    vin_d    = vin_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mul_a_d = a;
            mul_b_d = b;
            acc_d   = '0;
            cnt_d   = '0;
            cin_d   = carry_in;
            vin_d   = overflow_in;
            state_d = S_MUL;
          end else begin
            result_d = alu_res;
            flags_d  = nzcv(alu_res, alu_c, alu_v);
            done_d   = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d   = mul_sum;
        mul_a_d = mul_a_q << MUL_K;
        mul_b_d = mul_b_q >> MUL_K;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          result_d = mul_sum;
          flags_d  = nzcv(mul_sum, cin_q, vin_q);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      cin_q    <= 1'b0;
      vin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      cin_q    <= cin_d;
      vin_q    <= vin_d;
    end
  end

  assign busy   = (state_q == S_MUL);
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_arm_alu_mc.sv
// Scoreboard bench for arm_alu_mc: two instances, MUL_K=1 and MUL_K=4.
// Driver pushes expected result/flags/cycle; a negedge monitor pops on done.
module tb_arm_alu_mc;

  localparam logic [3:0] AND_ = 4'h0, EOR = 4'h1, SUB = 4'h2, RSB = 4'h3;
  localparam logic [3:0] ADD = 4'h4, ADC = 4'h5, SBC = 4'h6, MUL = 4'h7;
  localparam logic [3:0] LSL = 4'h8, LSR = 4'h9, ASR = 4'hA, ROR = 4'hB;
  localparam logic [3:0] ORR = 4'hC, MOV = 4'hD, BIC = 4'hE, MVN = 4'hF;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [3:0]  flg;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s   [2];
  logic        start_s [2];
  logic [3:0]  op_s    [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];
  logic [4:0]  sh_s    [2];
  logic        cin_s   [2];
  logic        vin_s   [2];
  logic        busy_w  [2];
  logic        done_w  [2];
  logic [31:0] res_w   [2];
  logic [3:0]  flg_w   [2];

  exp_t sb [2][$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arm_alu_mc #(.WIDTH(32), .MUL_K(1)) u_k1 (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .op(op_s[0]),
    .a(a_s[0]), .b(b_s[0]), .shamt(sh_s[0]),
    .carry_in(cin_s[0]), .overflow_in(vin_s[0]),
    .busy(busy_w[0]), .done(done_w[0]),
    .result(res_w[0]), .flags(flg_w[0])
  );

  arm_alu_mc #(.WIDTH(32), .MUL_K(4)) u_k4 (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .op(op_s[1]),
    .a(a_s[1]), .b(b_s[1]), .shamt(sh_s[1]),
    .carry_in(cin_s[1]), .overflow_in(vin_s[1]),
    .busy(busy_w[1]), .done(done_w[1]),
    .result(res_w[1]), .flags(flg_w[1])
  );

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (done_w[d] === 1'b1) begin
        if (sb[d].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done dut%0d: got done=1 at cycle %0d expected none",
                   d, cyc);
        end else begin
          exp_t e;
          e = sb[d].pop_front();
          chk({e.name, "_res"}, res_w[d], e.res);
          chk({e.name, "_nzcv"}, {28'd0, flg_w[d]}, {28'd0, e.flg});
          chk({e.name, "_cycle"}, cyc, e.cyc);
        end
      end
    end
  end

  task automatic issue(int d, string name, logic [3:0] op,
                       logic [31:0] a, logic [31:0] b, logic [4:0] sh,
                       logic cin, logic vin, logic [31:0] er,
                       logic [3:0] ef, int lat);
    op_s[d]    = op;
    a_s[d]     = a;
    b_s[d]     = b;
    sh_s[d]    = sh;
    cin_s[d]   = cin;
    vin_s[d]   = vin;
    start_s[d] = 1'b1;
    sb[d].push_back('{name, er, ef, cyc + lat});
    @(posedge clk);
    #1;
    start_s[d] = 1'b0;
  endtask

  task automatic drain(int d);
    int n = 0;
    while (sb[d].size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (sb[d].size() != 0) begin
      errors++;
      $display("FAIL drain_timeout dut%0d: got %0d pending expected 0",
               d, sb[d].size());
      sb[d].delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_s[d]   = 1'b1;
      start_s[d] = 1'b0;
      op_s[d]    = 4'h0;
      a_s[d]     = '0;
      b_s[d]     = '0;
      sh_s[d]    = '0;
      cin_s[d]   = 1'b0;
      vin_s[d]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b0;
      chk("reset_res", res_w[d], 32'd0);
      chk("reset_flags", {28'd0, flg_w[d]}, 32'd0);
      chk("reset_busy", {31'd0, busy_w[d]}, 32'd0);
      chk("reset_done", {31'd0, done_w[d]}, 32'd0);
    end

    issue(0, "add_ovf", ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 0, 0,
          32'h80000000, 4'b1001, 1);
    chk("add_busy", {31'd0, busy_w[0]}, 32'd0);
    drain(0);

    issue(0, "sub_eq", SUB, 32'd5, 32'd5, 5'd0, 0, 0,
          32'd0, 4'b0110, 1);
    issue(0, "sbc_00", SBC, 32'd0, 32'd0, 5'd0, 0, 0,
          32'hFFFFFFFF, 4'b1000, 1);
    issue(0, "lsr_1", LSR, 32'h80000001, 32'd0, 5'd1, 0, 0,
          32'h40000000, 4'b0010, 1);
    issue(0, "asr_31", ASR, 32'h80000000, 32'd0, 5'd31, 0, 0,
          32'hFFFFFFFF, 4'b1000, 1);
    issue(0, "ror_0", ROR, 32'h12345678, 32'd0, 5'd0, 1, 0,
          32'h12345678, 4'b0010, 1);
    issue(0, "and", AND_, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1, 1,
          32'hF000F000, 4'b1011, 1);
    issue(0, "eor", EOR, 32'hFFFF0000, 32'hFFFF0000, 5'd0, 0, 0,
          32'd0, 4'b0100, 1);
    issue(0, "rsb", RSB, 32'd3, 32'd10, 5'd0, 0, 0,
          32'd7, 4'b0010, 1);
    issue(0, "adc", ADC, 32'hFFFFFFFF, 32'd0, 5'd0, 1, 0,
          32'd0, 4'b0110, 1);
    issue(0, "add_negovf", ADD, 32'h80000000, 32'h80000000, 5'd0, 0, 0,
          32'd0, 4'b0111, 1);
    issue(0, "lsl_1", LSL, 32'h80000001, 32'd0, 5'd1, 0, 0,
          32'h00000002, 4'b0010, 1);
    issue(0, "lsl_31", LSL, 32'h1, 32'd0, 5'd31, 1, 0,
          32'h80000000, 4'b1000, 1);
    issue(0, "ror_1", ROR, 32'h1, 32'd0, 5'd1, 0, 0,
          32'h80000000, 4'b1010, 1);
    issue(0, "lsr_0", LSR, 32'h80000000, 32'd0, 5'd0, 0, 0,
          32'h80000000, 4'b1000, 1);
    issue(0, "orr", ORR, 32'h0F00, 32'h00F0, 5'd0, 0, 1,
          32'h0FF0, 4'b0001, 1);
    issue(0, "mov", MOV, 32'h1234, 32'd0, 5'd0, 1, 0,
          32'd0, 4'b0110, 1);
    issue(0, "bic", BIC, 32'hFFFFFFFF, 32'h0000FFFF, 5'd0, 0, 0,
          32'hFFFF0000, 4'b1000, 1);
    issue(0, "mvn", MVN, 32'h0, 32'h0, 5'd0, 0, 0,
          32'hFFFFFFFF, 4'b1000, 1);
    drain(0);

    issue(0, "mul_7x6", MUL, 32'd7, 32'd6, 5'd0, 0, 0,
          32'd42, 4'b0000, 33);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      chk("mul_busy", {31'd0, busy_w[0]}, 32'd1);
      if (i == 5) begin
        op_s[0]    = ADD;
        a_s[0]     = 32'd1;
        b_s[0]     = 32'd1;
        start_s[0] = 1'b1;
      end
      if (i == 6) start_s[0] = 1'b0;
    end
    @(negedge clk);
    chk("mul_busy_end", {31'd0, busy_w[0]}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mul_hold", res_w[0], 32'd42);
    drain(0);

    issue(0, "mul_abort", MUL, 32'd3, 32'd5, 5'd0, 0, 0,
          32'd15, 4'b0000, 33);
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_pre", {31'd0, busy_w[0]}, 32'd1);
    rst_s[0] = 1'b1;
    sb[0].delete();
    @(posedge clk);
    #1;
    rst_s[0] = 1'b0;
    chk("abort_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("abort_res", res_w[0], 32'd0);
    chk("abort_flags", {28'd0, flg_w[0]}, 32'd0);
    chk("abort_done", {31'd0, done_w[0]}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    issue(0, "add_post", ADD, 32'd2, 32'd3, 5'd0, 0, 0,
          32'd5, 4'b0000, 1);
    drain(0);

    issue(1, "mul_ff", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 0, 0,
          32'd1, 4'b0000, 9);
    chk("k4_busy", {31'd0, busy_w[1]}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("k4_busy_end", {31'd0, busy_w[1]}, 32'd0);
    issue(1, "add_in_done", ADD, 32'h10, 32'h20, 5'd0, 0, 0,
          32'h30, 4'b0000, 1);
    drain(1);
    issue(1, "mul_cv", MUL, 32'h12345, 32'h100, 5'd0, 1, 1,
          32'h01234500, 4'b0011, 9);
    drain(1);
    issue(1, "mul_zero", MUL, 32'h0, 32'h5, 5'd0, 0, 0,
          32'h0, 4'b0100, 9);
    drain(1);

    drain(0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
